// File: rtl/cavlc_coeff_count_pkg.sv
// Shared types for the CAVLC coefficient-count stage: zig-zag LUT, FSM states,
// coefficient width and the registered scalar result bundle.
package cavlc_coeff_count_pkg;

   localparam int CAVLC_COEF_W = 15;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_NCPRED,
      ST_OUT
   } state_t;

   typedef struct packed {
      logic [1:0] row;
      logic [1:0] col;
   } zz_pos_t;

   localparam zz_pos_t ZZ_LUT [0:15] = '{
      '{2'd0, 2'd0}, '{2'd0, 2'd1}, '{2'd1, 2'd0}, '{2'd2, 2'd0},
      '{2'd1, 2'd1}, '{2'd0, 2'd2}, '{2'd0, 2'd3}, '{2'd1, 2'd2},
      '{2'd2, 2'd1}, '{2'd3, 2'd0}, '{2'd3, 2'd1}, '{2'd2, 2'd2},
      '{2'd1, 2'd3}, '{2'd2, 2'd3}, '{2'd3, 2'd2}, '{2'd3, 2'd3}
   };

   typedef struct packed {
      logic [4:0] total_coeff;
      logic [1:0] trailing_ones;
      logic [2:0] t1_signs;
      logic [3:0] total_zeros;
      logic [4:0] nc;
   } cavlc_res_t;

endpackage

// File: rtl/cavlc_nc_buffer.sv
// Top/left TotalCoeff history of neighbouring 4x4 blocks and the nC prediction
// from them; only present when CAVLC_NC_PRED_EN is defined.
`ifdef CAVLC_NC_PRED_EN
module cavlc_nc_buffer #(
   parameter int FRAME_WIDTH  = 1920,
   parameter int FRAME_HEIGHT = 1088
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en_i,
   input  logic [9:0] x_i,
   input  logic [9:0] y_i,
   input  logic [4:0] tc_i,
   output logic [4:0] nc_o
);

   localparam int TOP_N  = FRAME_WIDTH / 4;
   localparam int LEFT_N = FRAME_HEIGHT / 4;
   localparam int TW     = $clog2(TOP_N);
   localparam int LW     = $clog2(LEFT_N);

   logic [4:0]    top_q  [0:TOP_N-1];
   logic [4:0]    left_q [0:LEFT_N-1];
   logic [TW-1:0] top_idx;
   logic [LW-1:0] left_idx;
   logic [4:0]    n_a;
   logic [4:0]    n_b;
   logic [5:0]    sum;
   logic          avail_a;
   logic          avail_b;

   assign top_idx  = TW'(x_i >> 2);
   assign left_idx = LW'(y_i >> 2);
   assign avail_a  = (x_i != 10'd0);
   assign avail_b  = (y_i != 10'd0);
   assign n_a      = left_q[left_idx];
   assign n_b      = top_q[top_idx];
   assign sum      = 6'(n_a) + 6'(n_b) + 6'd1;

   always_comb begin
      nc_o = 5'd0;
      case ({avail_a, avail_b})
         2'b11:   nc_o = sum[5:1];
         2'b10:   nc_o = n_a;
         2'b01:   nc_o = n_b;
         default: nc_o = 5'd0;
      endcase
   end

   // Reads above see the pre-write contents, so the current block never predicts from itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TOP_N; i++) top_q[i] <= 5'd0;
         for (int i = 0; i < LEFT_N; i++) left_q[i] <= 5'd0;
      end else if (wr_en_i) begin
         top_q[top_idx]   <= tc_i;
         left_q[left_idx] <= tc_i;
      end
   end

endmodule
`endif

// File: rtl/cavlc_coeff_count.sv
// Reverse zig-zag scan of one 4x4 block into CAVLC syntax parameters plus nC.
// Neighbour prediction is built only when CAVLC_NC_PRED_EN is defined.
module cavlc_coeff_count
   import cavlc_coeff_count_pkg::*;
#(
   parameter int FRAME_WIDTH  = 1920,
   parameter int FRAME_HEIGHT = 1088,
   parameter int COEF_W       = CAVLC_COEF_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     dctq_valid,
   input  logic [9:0]               topleft_x,
   input  logic [9:0]               topleft_y,
   input  logic signed [COEF_W-1:0] DCTQ_4x4 [0:3][0:3],
   output logic                     cavlc_cnt_ready,
   output logic                     coef_valid_o,
   input  logic                     coef_ready_i,
   output logic [4:0]               total_coeff_o,
   output logic [1:0]               trailing_ones_o,
   output logic [2:0]               t1_signs_o,
   output logic [3:0]               total_zeros_o,
   output logic [4:0]               nc_o,
   output logic signed [COEF_W-1:0] levels_o [0:15],
   output logic [3:0]               runs_o [0:15],
   output logic [9:0]               blk_x_o,
   output logic [9:0]               blk_y_o
);

   localparam logic signed [COEF_W-1:0] ONE       = COEF_W'(1);
   localparam logic signed [COEF_W-1:0] MINUS_ONE = '1;

   state_t                    state_q;
   logic [3:0]                idx_q;
   logic signed [COEF_W-1:0]  blk_q [0:3][0:3];
   logic [9:0]                x_q;
   logic [9:0]                y_q;
   logic [4:0]                tc_q;
   logic [1:0]                t1_q;
   logic [2:0]                signs_q;
   logic                      big_q;
   logic [4:0]                last_q;
   logic [3:0]                run_q;
   logic signed [COEF_W-1:0]  lvl_q [0:15];
   logic [3:0]                runs_q [0:15];
   cavlc_res_t                res_q;
   logic                      valid_q;
   logic                      ready_q;
   zz_pos_t                   pos;
   logic signed [COEF_W-1:0]  coef;
   logic                      coef_one;
   logic [4:0]                nc_d;

   assign pos      = ZZ_LUT[idx_q];
   assign coef     = blk_q[pos.row][pos.col];
   assign coef_one = (coef == ONE) || (coef == MINUS_ONE);

`ifdef CAVLC_NC_PRED_EN
   cavlc_nc_buffer #(
      .FRAME_WIDTH  (FRAME_WIDTH),
      .FRAME_HEIGHT (FRAME_HEIGHT)
   ) u_nc_buffer (
      .clk     (clk),
      .rst_n   (rst),
      .wr_en_i (state_q == ST_NCPRED),
      .x_i     (x_q),
      .y_i     (y_q),
      .tc_i    (tc_q),
      .nc_o    (nc_d)
   );
`else
   logic unused_cfg;
   assign unused_cfg = ^{FRAME_WIDTH, FRAME_HEIGHT};
   assign nc_d       = 5'd0;
`endif

   always_ff @(posedge clk) begin
      if (state_q == ST_IDLE && dctq_valid) blk_q <= DCTQ_4x4;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 4'd0;
         x_q     <= 10'd0;
         y_q     <= 10'd0;
         tc_q    <= 5'd0;
         t1_q    <= 2'd0;
         signs_q <= 3'd0;
         big_q   <= 1'b0;
         last_q  <= 5'd0;
         run_q   <= 4'd0;
         for (int i = 0; i < 16; i++) begin
            lvl_q[i]  <= '0;
            runs_q[i] <= 4'd0;
         end
         res_q   <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (dctq_valid) begin
                  state_q <= ST_SCAN;
                  ready_q <= 1'b0;
                  idx_q   <= 4'd15;
                  x_q     <= topleft_x;
                  y_q     <= topleft_y;
                  tc_q    <= 5'd0;
                  t1_q    <= 2'd0;
                  signs_q <= 3'd0;
                  big_q   <= 1'b0;
                  last_q  <= 5'd0;
                  run_q   <= 4'd0;
                  for (int i = 0; i < 16; i++) begin
                     lvl_q[i]  <= '0;
                     runs_q[i] <= 4'd0;
                  end
               end
            end
            // One scan position per cycle, highest frequency first.
            ST_SCAN: begin
               if (coef != '0) begin
                  lvl_q[tc_q[3:0]] <= coef;
                  if (tc_q != 5'd0) runs_q[tc_q[3:0] - 4'd1] <= run_q;
                  run_q <= 4'd0;
                  tc_q  <= tc_q + 5'd1;
                  if (tc_q == 5'd0) last_q <= {1'b0, idx_q} + 5'd1;
                  if (coef_one && !big_q && t1_q != 2'd3) begin
                     signs_q[t1_q] <= coef[COEF_W-1];
                     t1_q          <= t1_q + 2'd1;
                  end else if (!coef_one) begin
                     big_q <= 1'b1;
                  end
               end else if (tc_q != 5'd0) begin
                  run_q <= run_q + 4'd1;
               end
               if (idx_q == 4'd0) state_q <= ST_NCPRED;
               else               idx_q   <= idx_q - 4'd1;
            end
            ST_NCPRED: begin
               res_q.total_coeff   <= tc_q;
               res_q.trailing_ones <= t1_q;
               res_q.t1_signs      <= signs_q;
               res_q.total_zeros   <= 4'(last_q - tc_q);
               res_q.nc            <= nc_d;
               valid_q             <= 1'b1;
               state_q             <= ST_OUT;
            end
            ST_OUT: begin
               if (coef_ready_i) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cavlc_cnt_ready = ready_q;
   assign coef_valid_o    = valid_q;
   assign total_coeff_o   = res_q.total_coeff;
   assign trailing_ones_o = res_q.trailing_ones;
   assign t1_signs_o      = res_q.t1_signs;
   assign total_zeros_o   = res_q.total_zeros;
   assign nc_o            = res_q.nc;
   assign levels_o        = lvl_q;
   assign runs_o          = runs_q;
   assign blk_x_o         = x_q;
   assign blk_y_o         = y_q;

endmodule

// File: tb/tb_cavlc_coeff_count.sv
// Directed, table-driven bench for cavlc_coeff_count plus reset, backpressure
// and back-to-back sequences; nC expectations follow CAVLC_NC_PRED_EN.
module tb_cavlc_coeff_count;

   logic              clk = 1'b0;
   logic              rst;
   logic              dctq_valid;
   logic [9:0]        topleft_x;
   logic [9:0]        topleft_y;
   logic signed [14:0] blk_in [0:3][0:3];
   logic              cavlc_cnt_ready;
   logic              coef_valid_o;
   logic              coef_ready_i;
   logic [4:0]        total_coeff_o;
   logic [1:0]        trailing_ones_o;
   logic [2:0]        t1_signs_o;
   logic [3:0]        total_zeros_o;
   logic [4:0]        nc_o;
   logic signed [14:0] levels_o [0:15];
   logic [3:0]        runs_o [0:15];
   logic [9:0]        blk_x_o;
   logic [9:0]        blk_y_o;

   always #5 clk = ~clk;

   cavlc_coeff_count dut (
      .clk             (clk),
      .rst             (rst),
      .dctq_valid      (dctq_valid),
      .topleft_x       (topleft_x),
      .topleft_y       (topleft_y),
      .DCTQ_4x4        (blk_in),
      .cavlc_cnt_ready (cavlc_cnt_ready),
      .coef_valid_o    (coef_valid_o),
      .coef_ready_i    (coef_ready_i),
      .total_coeff_o   (total_coeff_o),
      .trailing_ones_o (trailing_ones_o),
      .t1_signs_o      (t1_signs_o),
      .total_zeros_o   (total_zeros_o),
      .nc_o            (nc_o),
      .levels_o        (levels_o),
      .runs_o          (runs_o),
      .blk_x_o         (blk_x_o),
      .blk_y_o         (blk_y_o)
   );

   typedef struct packed {
      logic [9:0]        x;
      logic [9:0]        y;
      logic [15:0][14:0] blk;   // raster order: entry r*4+c
      logic [4:0]        tc;
      logic [1:0]        t1;
      logic [2:0]        sg;
      logic [3:0]        tz;
      logic [4:0]        nc;
      logic [15:0][14:0] lv;
      logic [15:0][3:0]  rn;
   } vec_t;

   vec_t vecs [0:7];
   int   errors = 0;
   int   checks = 0;
   logic nc_en;

   function automatic logic [14:0] s(input int v);
      return v[14:0];
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [255:0] dut_levels();
      logic [15:0][14:0] p;
      for (int k = 0; k < 16; k++) p[k] = levels_o[k];
      return 256'(p);
   endfunction

   function automatic logic [255:0] dut_runs();
      logic [15:0][3:0] p;
      for (int k = 0; k < 16; k++) p[k] = runs_o[k];
      return 256'(p);
   endfunction

   task automatic drive_block(input vec_t v);
      topleft_x = v.x;
      topleft_y = v.y;
      for (int k = 0; k < 16; k++) blk_in[k / 4][k % 4] = v.blk[k];
   endtask

   task automatic apply_vec(input int i);
      vec_t v;
      int   n;
      v = vecs[i];
      drive_block(v);
      coef_ready_i = 1'b1;
      dctq_valid   = 1'b1;
      chk($sformatf("v%0d_ready_before", i), 256'(cavlc_cnt_ready), 256'(1));
      @(posedge clk); #1;
      dctq_valid = 1'b0;
      n = 1;   // capture edge counts as the first
      while (!coef_valid_o && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk($sformatf("v%0d_latency", i), 256'(n), 256'(18));
      chk($sformatf("v%0d_tc", i), 256'(total_coeff_o), 256'(v.tc));
      chk($sformatf("v%0d_t1", i), 256'(trailing_ones_o), 256'(v.t1));
      chk($sformatf("v%0d_t1signs", i), 256'(t1_signs_o), 256'(v.sg));
      chk($sformatf("v%0d_tz", i), 256'(total_zeros_o), 256'(v.tz));
      chk($sformatf("v%0d_nc", i), 256'(nc_o), 256'(v.nc));
      chk($sformatf("v%0d_levels", i), dut_levels(), 256'(v.lv));
      chk($sformatf("v%0d_runs", i), dut_runs(), 256'(v.rn));
      chk($sformatf("v%0d_xy", i), 256'({blk_x_o, blk_y_o}), 256'({v.x, v.y}));
      @(posedge clk); #1;
      chk($sformatf("v%0d_release", i), 256'({cavlc_cnt_ready, coef_valid_o}), 256'(2'b10));
   endtask

   initial begin
      int n;
      logic seen_high;
`ifdef CAVLC_NC_PRED_EN
      nc_en = 1'b1;
`else
      nc_en = 1'b0;
`endif
      for (int i = 0; i < 8; i++) vecs[i] = '0;

      // v0: all-zero block at (0,0)
      // v1: mixed block at (0,0); zeros below the top nonzero sit at scan 0,3,4,7
      vecs[1].blk[1] = s(3);  vecs[1].blk[4] = s(-1); vecs[1].blk[2] = s(-1);
      vecs[1].blk[3] = s(1);  vecs[1].blk[9] = s(1);
      vecs[1].tc = 5; vecs[1].t1 = 3; vecs[1].sg = 3'b100; vecs[1].tz = 4;
      vecs[1].lv[0] = s(1); vecs[1].lv[1] = s(1); vecs[1].lv[2] = s(-1);
      vecs[1].lv[3] = s(-1); vecs[1].lv[4] = s(3);
      vecs[1].rn[0] = 4'd1; vecs[1].rn[2] = 4'd2;
      // v2: every coefficient 2
      for (int k = 0; k < 16; k++) begin
         vecs[2].blk[k] = s(2);
         vecs[2].lv[k]  = s(2);
      end
      vecs[2].tc = 16;
      // v3: (0,0), four 5s at scan 0..3
      vecs[3].blk[0] = s(5); vecs[3].blk[1] = s(5); vecs[3].blk[4] = s(5); vecs[3].blk[8] = s(5);
      vecs[3].tc = 4;
      for (int k = 0; k < 4; k++) vecs[3].lv[k] = s(5);
      // v4: (4,0), scan 15 and 0 only -> run of 14, maximum total_zeros
      vecs[4].x = 10'd4;
      vecs[4].blk[0] = s(-1); vecs[4].blk[15] = s(1);
      vecs[4].tc = 2; vecs[4].t1 = 2; vecs[4].sg = 3'b010; vecs[4].tz = 14;
      vecs[4].lv[0] = s(1); vecs[4].lv[1] = s(-1); vecs[4].rn[0] = 4'd14;
      vecs[4].nc = nc_en ? 5'd4 : 5'd0;
      // v5: (0,4), large levels stop trailing ones immediately
      vecs[5].y = 10'd4;
      vecs[5].blk[0] = s(-3); vecs[5].blk[1] = s(7); vecs[5].blk[2] = s(2);
      vecs[5].blk[3] = s(-2); vecs[5].blk[5] = s(4); vecs[5].blk[10] = s(-5);
      vecs[5].tc = 6; vecs[5].tz = 6;
      vecs[5].lv[0] = s(-5); vecs[5].lv[1] = s(-2); vecs[5].lv[2] = s(2);
      vecs[5].lv[3] = s(4);  vecs[5].lv[4] = s(7);  vecs[5].lv[5] = s(-3);
      vecs[5].rn[0] = 4'd4; vecs[5].rn[3] = 4'd2;
      vecs[5].nc = nc_en ? 5'd4 : 5'd0;
      // v6: (4,4), four +-1 values, only three count as trailing ones
      vecs[6].x = 10'd4; vecs[6].y = 10'd4;
      vecs[6].blk[0] = s(1); vecs[6].blk[1] = s(-1); vecs[6].blk[4] = s(1); vecs[6].blk[8] = s(-1);
      vecs[6].tc = 4; vecs[6].t1 = 3; vecs[6].sg = 3'b101;
      vecs[6].lv[0] = s(-1); vecs[6].lv[1] = s(1); vecs[6].lv[2] = s(-1); vecs[6].lv[3] = s(1);
      vecs[6].nc = nc_en ? 5'd4 : 5'd0;
      // v7: (4,0) after a reset; cleared left buffer predicts 0
      vecs[7].x = 10'd4;
      vecs[7].blk[0] = s(2); vecs[7].blk[1] = s(2); vecs[7].blk[4] = s(2);
      vecs[7].tc = 3;
      for (int k = 0; k < 3; k++) vecs[7].lv[k] = s(2);

      rst = 1'b0; dctq_valid = 1'b0; coef_ready_i = 1'b0;
      drive_block(vecs[0]);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready_valid", 256'({cavlc_cnt_ready, coef_valid_o}), 256'(2'b10));
      chk("reset_scalars", 256'({total_coeff_o, trailing_ones_o, t1_signs_o, total_zeros_o, nc_o}), 256'(0));
      chk("reset_levels", dut_levels(), 256'(0));
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) apply_vec(i);

      // Reset in the middle of SCAN
      drive_block(vecs[6]);
      dctq_valid = 1'b1;
      @(posedge clk); #1;
      dctq_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midscan_rst_ready_valid", 256'({cavlc_cnt_ready, coef_valid_o}), 256'(2'b10));
      chk("midscan_rst_tc", 256'(total_coeff_o), 256'(0));
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_idle", 256'(cavlc_cnt_ready), 256'(1));
      apply_vec(7);

      // Backpressure with dctq_valid pulsed during OUT
      drive_block(vecs[5]);
      topleft_x = 10'd8; topleft_y = 10'd8;
      coef_ready_i = 1'b0;
      dctq_valid = 1'b1;
      @(posedge clk); #1;
      dctq_valid = 1'b0;
      n = 1;
      while (!coef_valid_o && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_latency", 256'(n), 256'(18));
      drive_block(vecs[2]);
      topleft_x = 10'd12; topleft_y = 10'd12;
      for (int k = 0; k < 5; k++) begin
         dctq_valid = (k % 2 == 0);
         @(posedge clk); #1;
         chk($sformatf("bp_hold%0d_ctl", k), 256'({coef_valid_o, cavlc_cnt_ready}), 256'(2'b10));
         chk($sformatf("bp_hold%0d_data", k), 256'({total_coeff_o, total_zeros_o, blk_x_o}), 256'({5'd6, 4'd6, 10'd8}));
         chk($sformatf("bp_hold%0d_levels", k), dut_levels(), 256'(vecs[5].lv));
      end
      dctq_valid = 1'b0;
      coef_ready_i = 1'b1;
      @(posedge clk); #1;
      chk("bp_release", 256'({cavlc_cnt_ready, coef_valid_o, blk_x_o}), 256'({2'b10, 10'd8}));

      // Back-to-back blocks with dctq_valid held high: accept-to-accept spacing
      drive_block(vecs[7]);
      dctq_valid = 1'b1;
      @(posedge clk); #1;
      chk("period_first_accept", 256'(cavlc_cnt_ready), 256'(0));
      n = 0;
      seen_high = 1'b0;
      while (n < 60 && !(seen_high && !cavlc_cnt_ready)) begin
         @(posedge clk); #1;
         n++;
         if (cavlc_cnt_ready) seen_high = 1'b1;
      end
      chk("period_19", 256'(n), 256'(19));
      dctq_valid = 1'b0;
      n = 0;
      while (!cavlc_cnt_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("period_drain", 256'(cavlc_cnt_ready), 256'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
